// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_if
// Description : Command/response handshake and APB bus bundle for apb_master.
//               "master" is the initiator view, "slave" the environment view.
// Revision    : 1.0
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB initiator (IDLE/SETUP/ACCESS/RESP).
//               Define APB_TIMEOUT_EN to bound the ACCESS wait at TIMEOUT_CYC.
// Revision    : 1.0
// ============================================================================
module apb_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  wire          clk,
    input  wire          rst,
    apb_master_if.master bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("apb_master: TIMEOUT_CYC must be in 1..65535");
        end
    endgenerate

    logic [1:0]        state_q,     state_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              access_done;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_hit;

    assign tmo_hit     = (tmo_cnt_q == c_TMO_LAST);
    assign access_done = bus.pready | tmo_hit;
`else
    assign access_done = bus.pready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (bus.cmd_valid) state_d = c_SETUP;
            c_SETUP:  state_d = c_ACCESS;
            c_ACCESS: if (access_done) state_d = c_RESP;
            c_RESP:   if (bus.rsp_ready) state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    // Address/data registers only move on command accept; the response
    // registers only move when ACCESS completes.
    always_comb begin
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                end
            end
            c_SETUP: begin
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            c_ACCESS: begin
                if (bus.pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == c_IDLE);
        bus.psel      = (state_q == c_SETUP) || (state_q == c_ACCESS);
        bus.penable   = (state_q == c_ACCESS);
        bus.rsp_valid = (state_q == c_RESP);
        bus.pwrite    = pwrite_q;
        bus.paddr     = paddr_q;
        bus.pwdata    = pwdata_q;
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Directed self-checking bench for apb_master; timeout scenarios
//               are included when APB_TIMEOUT_EN is defined (TIMEOUT_CYC=4).
// Revision    : 1.0
// ============================================================================
module tb_apb_master;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations collected by do_xfer for the scenario tasks to judge.
    int          o_lat;
    int          o_psel;
    int          o_pen;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_stable;
    logic        o_rsp_stable;
    logic        o_rdy_in_resp;
    logic        o_done;

    // Issues one command and plays the APB slave: pready rises after 'waits'
    // ACCESS cycles; off-cycle prdata/pslverr carry junk to catch bad sampling.
    task automatic do_xfer(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rd, input logic se,
                           input int hold, input logic stray);
        int   acc;
        int   held;
        logic seen;
        acc = 0; held = 0; seen = 1'b0;
        o_lat = -1; o_psel = 0; o_pen = 0; o_rdata = '0; o_err = 1'b0;
        o_stable = 1'b1; o_rsp_stable = 1'b1; o_rdy_in_resp = 1'b0; o_done = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr;
        bus.cmd_addr  = addr; bus.cmd_wdata = wdata;
        bus.pready    = 1'b0; bus.rsp_ready = 1'b0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.psel) begin
                o_psel++;
                if (bus.paddr !== addr || bus.pwdata !== wdata || bus.pwrite !== wr)
                    o_stable = 1'b0;
            end
            if (bus.penable) begin
                o_pen++;
                if (acc == waits) begin
                    bus.pready = 1'b1; bus.prdata = rd;  bus.pslverr = se;
                end else begin
                    bus.pready = 1'b0; bus.prdata = ~rd; bus.pslverr = ~se;
                end
                acc++;
            end else begin
                bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1; o_lat = cyc;
                    o_rdata = bus.rsp_rdata; o_err = bus.rsp_err;
                end else if (bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err) begin
                    o_rsp_stable = 1'b0;
                end
                if (bus.cmd_ready) o_rdy_in_resp = 1'b1;
                if (held < hold) begin
                    held++;
                    bus.rsp_ready = 1'b0;
                    if (stray) begin
                        bus.cmd_valid = 1'b1;
                        bus.cmd_write = ~wr;
                        bus.cmd_addr  = addr ^ 32'hFFFF_0000;
                    end
                end else begin
                    bus.rsp_ready = 1'b1;
                end
            end else if (seen) begin
                bus.rsp_ready = 1'b0;
                o_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got psel/pen/pwrite/rvalid/err=%b required 00000",
                     {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h required 0",
                     bus.paddr, bus.pwdata, bus.rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write();
        do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, 0, 1'b0);
        checks++;
        if (o_done !== 1'b1) begin errors++; $display("FAIL write_done: got %b required 1", o_done); end
        checks++;
        if (o_psel !== 2 || o_pen !== 1) begin
            errors++;
            $display("FAIL write_phases: got psel=%0d penable=%0d required 2/1", o_psel, o_pen);
        end
        checks++;
        if (o_stable !== 1'b1) begin errors++; $display("FAIL write_bus_fields: got stable=%b required 1", o_stable); end
        checks++;
        if (o_lat !== 3) begin errors++; $display("FAIL write_latency: got %0d required 3", o_lat); end
        checks++;
        if (o_err !== 1'b0 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp: got err=%b rdata=%h required 0/00000000", o_err, o_rdata);
        end
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 32'h0000_0020, 32'h0BAD_F00D, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
        checks++;
        if (o_pen !== 4 || o_psel !== 5) begin
            errors++;
            $display("FAIL read_wait_phases: got psel=%0d penable=%0d required 5/4", o_psel, o_pen);
        end
        checks++;
        if (o_stable !== 1'b1) begin errors++; $display("FAIL read_wait_stable: got %b required 1", o_stable); end
        checks++;
        if (o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL read_wait_rsp: got rdata=%h err=%b required 12345678/0", o_rdata, o_err);
        end
        checks++;
        if (o_lat !== 6) begin errors++; $display("FAIL read_wait_latency: got %0d required 6", o_lat); end
    endtask

    task automatic test_slverr();
        do_xfer(1'b0, 32'h0000_0030, 32'h0, 0, 32'hCAFE_0001, 1'b1, 0, 1'b0);
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL slverr_rsp: got err=%b rdata=%h required 1/cafe0001", o_err, o_rdata);
        end
        do_xfer(1'b0, 32'h0000_0034, 32'h0, 0, 32'h0000_0042, 1'b0, 0, 1'b0);
        checks++;
        if (o_err !== 1'b0 || o_rdata !== 32'h0000_0042) begin
            errors++;
            $display("FAIL slverr_clear: got err=%b rdata=%h required 0/00000042", o_err, o_rdata);
        end
    endtask

    task automatic test_backpressure();
        do_xfer(1'b1, 32'h0000_0040, 32'h1111_2222, 0, 32'h0, 1'b0, 5, 1'b1);
        checks++;
        if (o_done !== 1'b1 || o_rsp_stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_rsp_stable: got done=%b stable=%b required 1/1", o_done, o_rsp_stable);
        end
        checks++;
        if (o_rdy_in_resp !== 1'b0) begin
            errors++;
            $display("FAIL bp_cmd_ready: got cmd_ready-in-RESP=%b required 0", o_rdy_in_resp);
        end
        @(negedge clk);
        checks++;
        if (bus.psel !== 1'b0 || bus.paddr !== 32'h0000_0040 || bus.pwrite !== 1'b1) begin
            errors++;
            $display("FAIL bp_stray_ignored: got psel=%b paddr=%h pwrite=%b required 0/00000040/1",
                     bus.psel, bus.paddr, bus.pwrite);
        end
    endtask

    task automatic test_back_to_back();
        int n_ready;
        int n_rsp;
        n_ready = 0; n_rsp = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0050; bus.cmd_wdata = 32'h0;
        bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'h0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.cmd_ready) n_ready++;
            if (bus.rsp_valid) n_rsp++;
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.pready = 1'b0; bus.rsp_ready = 1'b0;
        checks++;
        if (n_ready !== 3 || n_rsp !== 3) begin
            errors++;
            $display("FAIL b2b_issue_rate: got accepts=%0d rsps=%0d in 12 cycles required 3/3",
                     n_ready, n_rsp);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        do_xfer(1'b0, 32'h0000_0060, 32'h0, 100, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
        checks++;
        if (o_done !== 1'b1 || o_pen !== 4 || o_lat !== 6) begin
            errors++;
            $display("FAIL timeout_phases: got done=%b penable=%0d lat=%0d required 1/4/6",
                     o_done, o_pen, o_lat);
        end
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b rdata=%h required 1/00000000", o_err, o_rdata);
        end
        do_xfer(1'b0, 32'h0000_0064, 32'h0, 3, 32'hA5A5_A5A5, 1'b1, 0, 1'b0);
        checks++;
        if (o_pen !== 4 || o_err !== 1'b1 || o_rdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL timeout_pready_wins: got penable=%0d err=%b rdata=%h required 4/1/a5a5a5a5",
                     o_pen, o_err, o_rdata);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic stale;
        stale = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0000_0070; bus.pready = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.penable !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_access: got penable=%b required 1", bus.penable);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got psel=%b penable=%b rsp_valid=%b required 0/0/0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.pready = 1'b1; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0 || bus.cmd_ready !== 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_release: got stale activity=%b required 0", stale);
        end
        checks++;
        if (bus.paddr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_paddr: got %h required 00000000", bus.paddr);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;   bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.prdata = '0;
        bus.pready    = 1'b0; bus.pslverr = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_backpressure();
        test_back_to_back();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
APB initiator that converts single commands from an internal valid/ready request port into APB SETUP/ACCESS transfers. It waits on pready and returns read data and error status on a valid/ready response port. It drives the APB slave bridges on the peripheral bus, including the register/SPI-side slave bridge. One transfer is outstanding at a time.

Parameters:
ADDR_W, 32, width of cmd_addr/paddr
DATA_W, 32, width of cmd_wdata/pwdata/prdata/rsp_rdata
TIMEOUT_CYC, 16, ACCESS-phase wait limit in cycles (used only when APB_TIMEOUT_EN defined; legal range 1..65535)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_err  output  1  slave error or timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready/wait
pslverr  input  1  APB slave error

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0. cmd_ready is 1 immediately after reset release.
- Reset asserted mid-transfer: the transfer is dropped without a response. psel/penable fall asynchronously.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid: latch cmd_write→pwrite, cmd_addr→paddr, cmd_wdata→pwdata (pwdata latched for reads too); next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0; next state ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pready=0: remain in ACCESS (wait state). paddr/pwrite/pwdata stay stable.
  - pready=1: rsp_rdata←(pwrite ? 0 : prdata), rsp_err←pslverr; psel=0, penable=0 next cycle; next state RESP.
  - pslverr is sampled only when pready=1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable.
  - On rsp_ready: rsp_valid=0 next cycle; next state IDLE.
  - rsp_ready=1 on the first RESP cycle is legal.
- paddr/pwrite/pwdata keep their last values after a transfer; they change only on command accept.
- Minimum latency, cmd accept to rsp_valid: 3 cycles (IDLE→SETUP→ACCESS→RESP) with zero wait states. Each wait state adds 1 cycle.
- Minimum issue interval: 4 cycles per command with rsp_ready held high.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle while pready=0.
  - When it reaches TIMEOUT_CYC with pready still 0: psel/penable drop next cycle, rsp_err=1, rsp_rdata=0, state→RESP.
  - If pready=1 in the same cycle the limit is hit, pready wins: normal completion with pslverr reported.
- Not defined: no counter logic; ACCESS waits indefinitely for pready.

Test Plan:
1. Write, pready tied 1: cmd addr=0x0000_0010, wdata=0xDEAD_BEEF → psel high 2 cycles, penable high 1 cycle, pwrite=1, paddr=0x10, pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
2. Read with 3 wait states, prdata=0x1234_5678 on the pready cycle → penable high 4 cycles; rsp_rdata=0x12345678; paddr stable throughout ACCESS.
3. Read with pslverr=1 and pready=1 → rsp_err=1. Next command then returns rsp_err=0.
4. rsp_ready held 0 for 5 cycles → rsp_valid and data stable; cmd_ready=0 and new cmd_valid ignored until the response is consumed.
5. rst driven low during ACCESS → psel/penable/rsp_valid = 0 asynchronously; after release, cmd_ready=1 and no stale response appears.
6. (APB_TIMEOUT_EN, TIMEOUT_CYC=4) pready held 0 → penable drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0. Separate run with pready rising on the 4th cycle → normal completion.
